float_minmax_reduce: RTL and testbench
======================================

FLOAT_MINMAX_REDUCE -- requirements
Module: float_minmax_reduce

Interface
REQ-001 Parameter FLOAT_WIDTH, default HALF_FLOAT_W, operand/result width.
REQ-002 Parameter COUNT_WIDTH, default 8, width of element-count field.
REQ-003 Parameter FLOAT_NAN, default HALF_NAN, canonical NaN encoding from fpu_types_pkg.
REQ-004 CLK  input  1  single clock, all state on rising edge.
REQ-005 nRST  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse launching a reduction; honoured only in IDLE.
REQ-007 max  input  1  sampled with start; 1 = maximum, 0 = minimum.
REQ-008 count  input  COUNT_WIDTH  sampled with start; number of elements to reduce.
REQ-009 in_valid  input  1  in_data holds a valid element.
REQ-010 in_data  input  FLOAT_WIDTH  element to reduce.
REQ-011 in_ready  output  1  block accepts in_data this cycle.
REQ-012 out_valid  output  1  out_data holds the final result.
REQ-013 out_data  output  FLOAT_WIDTH  reduction result.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, FIRST, ACCUM, DONE.
REQ-017 IDLE: on start with count!=0, latch max/count into op/remaining, go FIRST; with count==0, load accumulator with FLOAT_NAN, go DONE; start while not IDLE SHALL be ignored.
REQ-018 in_ready SHALL be 1 only in FIRST and ACCUM; element accepted on a cycle with in_valid&&in_ready.
REQ-019 FIRST: accepted element loads accumulator unmodified, remaining decrements; go DONE if remaining was 1, else ACCUM.
REQ-020 ACCUM: accepted element x updates accumulator a := select(a, x, op), remaining decrements; go DONE when the element accepted had remaining==1.
REQ-021 Throughput SHALL be one element per cycle; in_valid low stalls with no state change.
REQ-022 DONE: out_valid=1, out_data=accumulator held stable until out_valid&&out_ready, then return to IDLE in the next cycle; out_valid SHALL rise the cycle after the last element is accepted.
REQ-023 select rules, in priority: both operands equal FLOAT_NAN -> FLOAT_NAN; one operand equals FLOAT_NAN -> the other; differing signs -> positive operand for max, negative for min; same sign -> compare {exponent,fraction} as unsigned magnitude, larger magnitude is larger for positive and smaller for negative; equal encodings -> keep a.
REQ-024 -0 SHALL order below +0; -inf/+inf SHALL order naturally via REQ-023 magnitude rule.
REQ-025 Remaining counter SHALL be COUNT_WIDTH bits; count = 2**COUNT_WIDTH-1 SHALL reduce that many elements without wrap.
REQ-026 op SHALL not change mid-reduction regardless of max input.

Reset
REQ-027 On nRST low, asynchronously: state IDLE, accumulator 0, remaining 0, op 0; outputs in_ready=0, out_valid=0, out_data=0, busy=0.
REQ-028 Reset asserted mid-reduction SHALL abandon it; no out_valid after release until a new start completes.

Verification
REQ-029 max=1, count=4, elements 0x3C00, 0xC200, 0x4000, 0x3C00 back-to-back -> out_valid 1 cycle after 4th accept, out_data 0x4000.
REQ-030 max=0, same stream with in_valid gaps -> out_data 0xC200, in_ready high throughout, result unaffected by gaps.
REQ-031 max=1, count=3, elements 0x7E00, 0xFC00, 0x7E00 -> out_data 0xFC00; count=2 all 0x7E00 -> out_data 0x7E00.
REQ-032 max=0, count=2, elements 0x0000, 0x8000 -> out_data 0x8000; count=0 -> out_valid next cycle, out_data 0x7E00.
REQ-033 out_ready held low 5 cycles in DONE -> out_data stable, start pulses ignored, busy=1; out_ready high -> IDLE next cycle.
REQ-034 nRST pulsed after 2 of 4 elements -> all outputs 0 immediately; new start count=1, element 0x4000 -> out_data 0x4000.

Source files
------------

// File: rtl/float_minmax_reduce_if.sv
// Bundle of control, element-stream and result signals for float_minmax_reduce.
// Both streams are valid/ready: a transfer happens on a rising clock edge where valid && ready are both high.
interface float_minmax_reduce_if #(
    parameter int W  = 16,
    parameter int CW = 8
);
    logic          start;
    logic          max;
    logic [CW-1:0] count;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          busy;

    modport master (
        output start, max, count, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  start, max, count, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/float_minmax_reduce.sv
// Streaming min/max reduction over a counted sequence of IEEE-style floats.
// The canonical NaN encoding is treated as "no value" and loses to any other operand.
package fpu_types_pkg;
    localparam int          HALF_FLOAT_W = 16;
    localparam logic [15:0] HALF_NAN     = 16'h7E00;
endpackage

module float_minmax_reduce
    import fpu_types_pkg::*;
#(
    parameter int                     FLOAT_WIDTH = HALF_FLOAT_W,
    parameter int                     COUNT_WIDTH = 8,
    parameter logic [FLOAT_WIDTH-1:0] FLOAT_NAN   = HALF_NAN
) (
    input  logic                  CLK,
    input  logic                  nRST,
    float_minmax_reduce_if.slave  bus,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    state_t                 state;
    logic [FLOAT_WIDTH-1:0] acc;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   op;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic                   busy_r;

    // Sign-magnitude ordering: -0 < +0, and infinities fall out of the magnitude compare.
    function automatic logic [FLOAT_WIDTH-1:0] select_fn(
        input logic [FLOAT_WIDTH-1:0] a,
        input logic [FLOAT_WIDTH-1:0] x,
        input logic                   want_max
    );
        logic x_larger;
        if (a == FLOAT_NAN && x == FLOAT_NAN) begin
            return FLOAT_NAN;
        end else if (a == FLOAT_NAN) begin
            return x;
        end else if (x == FLOAT_NAN) begin
            return a;
        end else if (a[FLOAT_WIDTH-1] != x[FLOAT_WIDTH-1]) begin
            if (want_max) return a[FLOAT_WIDTH-1] ? x : a;
            else          return a[FLOAT_WIDTH-1] ? a : x;
        end else if (a[FLOAT_WIDTH-2:0] == x[FLOAT_WIDTH-2:0]) begin
            return a;
        end else begin
            x_larger = x[FLOAT_WIDTH-1] ? (x[FLOAT_WIDTH-2:0] < a[FLOAT_WIDTH-2:0])
                                        : (x[FLOAT_WIDTH-2:0] > a[FLOAT_WIDTH-2:0]);
            return (want_max == x_larger) ? x : a;
        end
    endfunction

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            acc         <= '0;
            remaining   <= '0;
            op          <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        if (bus.count != '0) begin
                            op         <= bus.max;
                            remaining  <= bus.count;
                            in_ready_r <= 1'b1;
                            state      <= FIRST;
                        end else begin
                            acc         <= FLOAT_NAN;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                FIRST, ACCUM: begin
                    if (bus.in_valid) begin
                        acc       <= (state == FIRST) ? bus.in_data
                                                      : select_fn(acc, bus.in_data, op);
                        remaining <= remaining - ONE;
                        if (remaining == ONE) begin
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = acc;
    assign bus.busy      = busy_r;
    assign state_dbg     = state;

endmodule

// File: tb/tb_float_minmax_reduce.sv
// Directed bench for float_minmax_reduce: hand-computed reductions queued in exp_q and
// compared when each result is handed off.
module tb_float_minmax_reduce;
    localparam int W  = 16;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    float_minmax_reduce_if #(.W(W), .CW(CW)) bus ();

    float_minmax_reduce #(
        .FLOAT_WIDTH(W),
        .COUNT_WIDTH(CW),
        .FLOAT_NAN  (16'h7E00)
    ) dut (
        .CLK      (clk),
        .nRST     (rst_n),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic start_op(input logic mx, input logic [CW-1:0] cnt, input logic [W-1:0] exp);
        bus.start = 1'b1;
        bus.max   = mx;
        bus.count = cnt;
        exp_q.push_back(exp);
        tick();
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
    endtask

    task automatic send(input logic [W-1:0] d, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            bus.in_valid = 1'b0;
            tick();
            check("in_ready_gap", bus.in_ready, 1);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag);
        int n;
        logic [W-1:0] exp;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_expq"}, 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check({tag, "_data"}, bus.out_data, exp);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_idle_busy"}, bus.busy, 0);
        check({tag, "_idle_valid"}, bus.out_valid, 0);
        check({tag, "_idle_state"}, state_dbg, 0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.max       = 1'b0;
        bus.count     = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_state", state_dbg, 0);
        rst_n = 1'b1;
        tick();

        // max, back-to-back
        start_op(1'b1, 8'd4, 16'h4000);
        send(16'h3C00, 0);
        send(16'hC200, 0);
        send(16'h4000, 0);
        check("t029_not_early", bus.out_valid, 0);
        send(16'h3C00, 0);
        check("t029_latency", bus.out_valid, 1);
        get_result("t029");

        // min with in_valid gaps
        start_op(1'b0, 8'd4, 16'hC200);
        send(16'h3C00, 2);
        send(16'hC200, 1);
        send(16'h4000, 3);
        send(16'h3C00, 0);
        check("t030_latency", bus.out_valid, 1);
        get_result("t030");

        // NaN handling
        start_op(1'b1, 8'd3, 16'hFC00);
        send(16'h7E00, 0);
        send(16'hFC00, 0);
        send(16'h7E00, 0);
        get_result("t031_nan_first");
        start_op(1'b1, 8'd2, 16'h7E00);
        send(16'h7E00, 0);
        send(16'h7E00, 0);
        get_result("t031_all_nan");

        // signed zero and empty reduction
        start_op(1'b0, 8'd2, 16'h8000);
        send(16'h0000, 0);
        send(16'h8000, 0);
        get_result("t032_zero_min");
        start_op(1'b0, 8'd0, 16'h7E00);
        check("t032_empty_valid", bus.out_valid, 1);
        check("t032_empty_in_ready", bus.in_ready, 0);
        get_result("t032_empty");

        start_op(1'b1, 8'd2, 16'h0000);
        send(16'h8000, 0);
        send(16'h0000, 0);
        get_result("zero_max");
        start_op(1'b1, 8'd2, 16'h7C00);
        send(16'hFC00, 0);
        send(16'h7C00, 0);
        get_result("inf_max");
        start_op(1'b0, 8'd3, 16'hC400);
        send(16'hC200, 0);
        send(16'hC400, 0);
        send(16'hBC00, 0);
        get_result("neg_min");

        // op latched at start: flipping max mid-run must not matter
        start_op(1'b1, 8'd2, 16'h4000);
        bus.max = 1'b0;
        send(16'h3C00, 0);
        send(16'h4000, 0);
        get_result("op_latched");

        // result held while consumer stalls; start ignored in DONE
        start_op(1'b1, 8'd1, 16'h4400);
        send(16'h4400, 0);
        for (int i = 0; i < 5; i++) begin
            bus.start = 1'b1;
            bus.count = 8'd1;
            tick();
            check("t033_hold_data", bus.out_data, 16'h4400);
            check("t033_hold_valid", bus.out_valid, 1);
            check("t033_hold_busy", bus.busy, 1);
            check("t033_hold_in_ready", bus.in_ready, 0);
        end
        bus.start = 1'b0;
        get_result("t033");

        // full-length count, no wrap
        start_op(1'b1, 8'd255, 16'h7BFF);
        for (int i = 0; i < 255; i++) begin
            send((i == 200) ? 16'h7BFF : 16'h3C00, 0);
            if (i == 253) check("max_count_not_early", bus.out_valid, 0);
        end
        check("max_count_latency", bus.out_valid, 1);
        get_result("max_count");

        // reset mid-reduction
        bus.start = 1'b1;
        bus.max   = 1'b1;
        bus.count = 8'd4;
        tick();
        bus.start = 1'b0;
        send(16'h3C00, 0);
        send(16'h4000, 0);
        rst_n = 1'b0;
        #1;
        check("t034_rst_in_ready", bus.in_ready, 0);
        check("t034_rst_out_valid", bus.out_valid, 0);
        check("t034_rst_out_data", bus.out_data, 0);
        check("t034_rst_busy", bus.busy, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t034_no_valid", bus.out_valid, 0);
            check("t034_idle_busy", bus.busy, 0);
        end
        start_op(1'b1, 8'd1, 16'h4000);
        send(16'h4000, 0);
        get_result("t034_restart");

        check("exp_q_drained", exp_q.size(), 0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
